// File: rtl/sysid_probe_ctrl_if.sv
// -----------------------------------------------------------------------------
// sysid_probe_ctrl_if
// Avalon-MM read-only bus between the system-ID probe (master) and the
// system-ID peripheral (slave).
//   avm_address       : word address, 0 = ID register, 1 = timestamp register
//   avm_read          : read strobe, held with address while avm_waitrequest=1
//   avm_waitrequest   : slave stall
//   avm_readdata      : 32-bit read data
//   avm_readdatavalid : qualifies avm_readdata
// -----------------------------------------------------------------------------
interface sysid_probe_ctrl_if;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata,
        input  avm_readdatavalid
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata,
        output avm_readdatavalid
    );
endinterface

// File: rtl/sysid_probe_ctrl.sv
// -----------------------------------------------------------------------------
// sysid_probe_ctrl
// Reads the system-ID word and then the timestamp word over Avalon-MM,
// captures both and flags whether the ID matches EXPECTED_ID.
//
// Parameters
//   EXPECTED_ID    : ID value the captured word is compared against
//   TIMEOUT_CYCLES : per-transaction cycle limit (1..255, 8-bit counter)
//
// Ports
//   clock       : single clock, rising edge
//   reset_n     : asynchronous active-low reset
//   start       : one-cycle request to run a probe sequence (ignored while busy)
//   avm         : Avalon-MM master side (sysid_probe_ctrl_if.master)
//   busy        : high from sequence start until done (low in IDLE only)
//   done        : one-cycle pulse at sequence end
//   id_value    : captured ID word
//   ts_value    : captured timestamp word
//   id_match    : id_value == EXPECTED_ID, held until next accepted start
//   timeout_err : sticky, a read exceeded TIMEOUT_CYCLES
//
// Build option
//   SYSID_PROBE_TIMEOUT_EN : compiles in the per-transaction timeout counter.
//   Without it timeout_err is tied low and the controller waits indefinitely.
// -----------------------------------------------------------------------------
module sysid_probe_ctrl #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    sysid_probe_ctrl_if.master avm,
    output logic               busy,
    output logic               done,
    output logic [31:0]        id_value,
    output logic [31:0]        ts_value,
    output logic               id_match,
    output logic               timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        WAIT_ID,
        RD_TS,
        WAIT_TS,
        DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_id_value;
    logic [31:0] r_ts_value;
    logic        r_id_match;

    logic        w_rd_state;
    logic        w_wait_state;
    logic        w_id_phase;
    logic        w_accept;
    logic        w_capture;
    logic        w_timeout;
    logic        w_start_acc;

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
        $error("sysid_probe_ctrl: TIMEOUT_CYCLES must be in 1..255");
    end

    assign w_rd_state   = (r_state == RD_ID)   || (r_state == RD_TS);
    assign w_wait_state = (r_state == WAIT_ID) || (r_state == WAIT_TS);
    assign w_id_phase   = (r_state == RD_ID)   || (r_state == WAIT_ID);
    assign w_start_acc  = (r_state == IDLE) && start;

    // A read is accepted when the strobe is out and the slave is not stalling.
    assign w_accept  = w_rd_state && !avm.avm_waitrequest && !w_timeout;
    // Data is taken either in a WAIT state or, for a zero-latency slave, in the
    // very cycle the read is accepted; any other readdatavalid is ignored.
    assign w_capture = avm.avm_readdatavalid &&
                       (w_accept || (w_wait_state && !w_timeout));

`ifdef SYSID_PROBE_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic       r_timeout_err;
    logic       w_enter_rd;

    assign w_enter_rd = ((w_next == RD_ID) || (w_next == RD_TS)) && (w_next != r_state);
    assign w_timeout  = (w_rd_state || w_wait_state) && (r_cnt == 8'(TIMEOUT_CYCLES));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_enter_rd) begin
            r_cnt <= '0;
        end else if (w_rd_state || w_wait_state) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_timeout_err <= 1'b0;
        end else if (w_start_acc) begin
            r_timeout_err <= 1'b0;
        end else if (w_timeout) begin
            r_timeout_err <= 1'b1;
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_next = RD_ID;
            end
            RD_ID: begin
                if (w_timeout)     w_next = DONE;
                else if (w_accept) w_next = w_capture ? RD_TS : WAIT_ID;
            end
            WAIT_ID: begin
                if (w_timeout)      w_next = DONE;
                else if (w_capture) w_next = RD_TS;
            end
            RD_TS: begin
                if (w_timeout)     w_next = DONE;
                else if (w_accept) w_next = w_capture ? DONE : WAIT_TS;
            end
            WAIT_TS: begin
                if (w_timeout)      w_next = DONE;
                else if (w_capture) w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        avm.avm_read    = w_rd_state && !w_timeout;
        avm.avm_address = (r_state == RD_TS) || (r_state == WAIT_TS);
        busy            = (r_state != IDLE);
        done            = (r_state == DONE);
    end

    // Captured data and match flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_id_value <= '0;
            r_ts_value <= '0;
            r_id_match <= 1'b0;
        end else if (w_start_acc || w_timeout) begin
            r_id_match <= 1'b0;
        end else if (w_capture) begin
            if (w_id_phase) begin
                r_id_value <= avm.avm_readdata;
                r_id_match <= (avm.avm_readdata == EXPECTED_ID);
            end else begin
                r_ts_value <= avm.avm_readdata;
            end
        end
    end

    assign id_value = r_id_value;
    assign ts_value = r_ts_value;
    assign id_match = r_id_match;

endmodule

// File: tb/tb_sysid_probe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sysid_probe_ctrl
// Directed bench for sysid_probe_ctrl. The bench plays the Avalon slave by hand,
// cycle by cycle. Cycle 0 is the cycle in which start is driven high.
// -----------------------------------------------------------------------------
module tb_sysid_probe_ctrl;

    localparam logic [31:0] EXP_ID = 32'h6068_33B6;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] id_value;
    logic [31:0] ts_value;
    logic        id_match;
    logic        timeout_err;

    int checks;
    int errors;
    int done_seen;
    int done_before;

    sysid_probe_ctrl_if bus ();

    sysid_probe_ctrl #(
        .EXPECTED_ID    (EXP_ID),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .avm         (bus.master),
        .busy        (busy),
        .done        (done),
        .id_value    (id_value),
        .ts_value    (ts_value),
        .id_match    (id_match),
        .timeout_err (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
        if (done === 1'b1) done_seen++;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_read"},   32'(bus.avm_read),    32'd0);
        check({tag, "_addr"},   32'(bus.avm_address), 32'd0);
        check({tag, "_busy"},   32'(busy),            32'd0);
        check({tag, "_done"},   32'(done),            32'd0);
        check({tag, "_id"},     id_value,             32'd0);
        check({tag, "_ts"},     ts_value,             32'd0);
        check({tag, "_match"},  32'(id_match),        32'd0);
        check({tag, "_tmo"},    32'(timeout_err),     32'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        done_seen = 0;
        reset_n   = 1'b0;
        start     = 1'b0;
        bus.avm_waitrequest   = 1'b0;
        bus.avm_readdata      = '0;
        bus.avm_readdatavalid = 1'b0;
        #1;
        check_all_zero("rst");
        step();
        step();
        reset_n = 1'b1;
        step();

        // Stray readdatavalid in IDLE must not be captured
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = 32'hDEAD_BEEF;
        step();
        bus.avm_readdatavalid = 1'b0;
        check("idle_valid_ignored", id_value, 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // ---- A: nominal, zero wait, latency 1, done at cycle 5 ----
        start = 1'b1;                                    // cycle 0
        step();                                          // cycle 1
        start = 1'b0;
        check("A_c1_read", 32'(bus.avm_read), 32'd1);
        check("A_c1_addr", 32'(bus.avm_address), 32'd0);
        check("A_c1_busy", 32'(busy), 32'd1);
        step();                                          // cycle 2
        check("A_c2_read", 32'(bus.avm_read), 32'd0);
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = EXP_ID;
        step();                                          // cycle 3
        bus.avm_readdatavalid = 1'b0;
        check("A_c3_read", 32'(bus.avm_read), 32'd1);
        check("A_c3_addr", 32'(bus.avm_address), 32'd1);
        check("A_c3_id", id_value, EXP_ID);
        step();                                          // cycle 4
        check("A_c4_done", 32'(done), 32'd0);
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = 32'h0000_1234;
        step();                                          // cycle 5
        bus.avm_readdatavalid = 1'b0;
        check("A_c5_done", 32'(done), 32'd1);
        check("A_c5_match", 32'(id_match), 32'd1);
        check("A_c5_ts", ts_value, 32'h0000_1234);
        step();                                          // cycle 6
        check("A_c6_done", 32'(done), 32'd0);
        check("A_c6_busy", 32'(busy), 32'd0);
        check("A_c6_match_held", 32'(id_match), 32'd1);

        // ---- B: mismatching ID, zero-latency slave ----
        start = 1'b1;                                    // cycle 0
        step();                                          // cycle 1
        start = 1'b0;
        check("B_c1_match_clr", 32'(id_match), 32'd0);
        check("B_c1_read", 32'(bus.avm_read), 32'd1);
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = 32'h0000_0001;
        step();                                          // cycle 2
        check("B_c2_read", 32'(bus.avm_read), 32'd1);
        check("B_c2_addr", 32'(bus.avm_address), 32'd1);
        check("B_c2_id", id_value, 32'h0000_0001);
        bus.avm_readdata      = 32'h0000_ABCD;
        step();                                          // cycle 3
        bus.avm_readdatavalid = 1'b0;
        check("B_c3_done", 32'(done), 32'd1);
        check("B_c3_match", 32'(id_match), 32'd0);
        check("B_c3_ts", ts_value, 32'h0000_ABCD);
        step();

        // ---- C: 3 waitrequest cycles on ID read, start while busy ----
        done_before = done_seen;
        start = 1'b1;                                    // cycle 0
        step();                                          // cycle 1
        start = 1'b0;
        bus.avm_waitrequest = 1'b1;
        check("C_c1_read", 32'(bus.avm_read), 32'd1);
        check("C_c1_addr", 32'(bus.avm_address), 32'd0);
        step();                                          // cycle 2
        start = 1'b1;
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = 32'hDEAD_BEEF;
        check("C_c2_read", 32'(bus.avm_read), 32'd1);
        check("C_c2_addr", 32'(bus.avm_address), 32'd0);
        step();                                          // cycle 3
        start = 1'b0;
        bus.avm_readdatavalid = 1'b0;
        check("C_c3_read", 32'(bus.avm_read), 32'd1);
        check("C_c3_addr", 32'(bus.avm_address), 32'd0);
        step();                                          // cycle 4
        bus.avm_waitrequest = 1'b0;
        check("C_c4_read", 32'(bus.avm_read), 32'd1);
        check("C_c4_addr", 32'(bus.avm_address), 32'd0);
        step();                                          // cycle 5
        check("C_c5_read", 32'(bus.avm_read), 32'd0);
        check("C_c5_id_not_early", id_value, 32'h0000_0001);
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = EXP_ID;
        step();                                          // cycle 6
        bus.avm_readdatavalid = 1'b0;
        check("C_c6_addr", 32'(bus.avm_address), 32'd1);
        step();                                          // cycle 7
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = 32'h0000_5555;
        step();                                          // cycle 8
        bus.avm_readdatavalid = 1'b0;
        check("C_c8_done", 32'(done), 32'd1);
        check("C_c8_match", 32'(id_match), 32'd1);
        check("C_c8_ts", ts_value, 32'h0000_5555);
        for (int i = 0; i < 6; i++) step();
        check("C_one_done", 32'(done_seen - done_before), 32'd1);
        check("C_idle_busy", 32'(busy), 32'd0);

        // ---- D: reset during WAIT_TS, late readdatavalid ----
        done_before = done_seen;
        start = 1'b1;                                    // cycle 0
        step();                                          // cycle 1
        start = 1'b0;
        step();                                          // cycle 2
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = EXP_ID;
        step();                                          // cycle 3
        bus.avm_readdatavalid = 1'b0;
        step();                                          // cycle 4 (WAIT_TS)
        check("D_c4_addr", 32'(bus.avm_address), 32'd1);
        reset_n = 1'b0;
        #1;
        check_all_zero("D_async");
        step();
        reset_n = 1'b1;
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = 32'hFFFF_FFFF;
        step();
        bus.avm_readdatavalid = 1'b0;
        step();
        check_all_zero("D_after");
        check("D_no_done", 32'(done_seen - done_before), 32'd0);

        // ---- E: waitrequest stuck high ----
        done_before = done_seen;
        bus.avm_waitrequest = 1'b1;
        start = 1'b1;                                    // cycle 0
        step();                                          // cycle 1
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("E_c%0d_read", c), 32'(bus.avm_read), 32'd1);
            step();
        end                                              // now cycle 9
`ifdef SYSID_PROBE_TIMEOUT_EN
        check("E_c9_done", 32'(done), 32'd0);
        step();                                          // cycle 10
        check("E_c10_done", 32'(done), 32'd1);
        check("E_c10_tmo", 32'(timeout_err), 32'd1);
        check("E_c10_match", 32'(id_match), 32'd0);
        check("E_c10_read", 32'(bus.avm_read), 32'd0);
        step();
        check("E_tmo_sticky", 32'(timeout_err), 32'd1);
        check("E_busy", 32'(busy), 32'd0);
        bus.avm_waitrequest = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("E_tmo_clr", 32'(timeout_err), 32'd0);
`else
        for (int c = 9; c <= 14; c++) begin
            check($sformatf("E_c%0d_read_held", c), 32'(bus.avm_read), 32'd1);
            step();
        end
        check("E_no_done", 32'(done_seen - done_before), 32'd0);
        check("E_tmo_zero", 32'(timeout_err), 32'd0);
        check("E_busy", 32'(busy), 32'd1);
        bus.avm_waitrequest = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sysid_probe_ctrl.md
SYSID_PROBE_CTRL -- requirements
Module: sysid_probe_ctrl

Interface
REQ-001 SHALL have parameter: EXPECTED_ID, 32'h0000_0000, system ID value the probe compares against.
REQ-002 SHALL have parameter: TIMEOUT_CYCLES, 255, maximum cycles allowed per read transaction (8-bit counter, range 1..255).
REQ-003 SHALL have port: clock  input  1  single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port: reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port: start  input  1  one-cycle request to run a probe sequence.
REQ-006 SHALL have port: avm_address  output  1  Avalon-MM word address; 0 = ID register, 1 = timestamp register.
REQ-007 SHALL have port: avm_read  output  1  Avalon-MM read strobe.
REQ-008 SHALL have port: avm_waitrequest  input  1  slave stall; read held while high.
REQ-009 SHALL have port: avm_readdata  input  32  read data.
REQ-010 SHALL have port: avm_readdatavalid  input  1  qualifies avm_readdata.
REQ-011 SHALL have port: busy  output  1  high from sequence start until done.
REQ-012 SHALL have port: done  output  1  one-cycle pulse at sequence end.
REQ-013 SHALL have port: id_value  output  32  captured ID word.
REQ-014 SHALL have port: ts_value  output  32  captured timestamp word.
REQ-015 SHALL have port: id_match  output  1  id_value == EXPECTED_ID, valid when done pulses; held until next start.
REQ-016 SHALL have port: timeout_err  output  1  sticky flag, a read exceeded TIMEOUT_CYCLES.

Function
REQ-017 SHALL implement states IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, DONE.
REQ-018 SHALL move IDLE->RD_ID on start=1; start while busy SHALL be ignored.
REQ-019 In RD_ID, SHALL drive avm_read=1, avm_address=0; hold both stable while avm_waitrequest=1; go to WAIT_ID in the cycle after a cycle with avm_read=1 and avm_waitrequest=0.
REQ-020 In WAIT_ID, SHALL drive avm_read=0; on avm_readdatavalid=1 capture avm_readdata into id_value and go to RD_TS.
REQ-021 RD_TS/WAIT_TS SHALL behave as RD_ID/WAIT_ID with avm_address=1, capturing into ts_value, then go to DONE.
REQ-022 Readdatavalid arriving in the same cycle the read is accepted (zero latency) SHALL be captured directly, skipping the WAIT state.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE; busy=0 in IDLE only.
REQ-024 id_match SHALL be registered when id_value is captured; cleared to 0 on start acceptance.
REQ-025 avm_readdatavalid outside WAIT_ID/WAIT_TS/accept cycles SHALL be ignored.
REQ-026 Minimum sequence latency, zero-wait one-cycle-latency slave: start at cycle 0 -> done=1 at cycle 5.

Reset
REQ-027 reset_n=0 SHALL asynchronously force IDLE; avm_read=0, avm_address=0, busy=0, done=0, id_value=0, ts_value=0, id_match=0, timeout_err=0, timeout counter=0.
REQ-028 Reset asserted mid-sequence SHALL abandon the transaction; late readdatavalid after reset release SHALL be ignored.

Configuration
REQ-029 Macro SYSID_PROBE_TIMEOUT_EN SHALL compile in a per-transaction cycle counter, cleared on entry to each RD state, counting every cycle in RD/WAIT states.
REQ-030 With SYSID_PROBE_TIMEOUT_EN defined, counter reaching TIMEOUT_CYCLES SHALL set timeout_err=1, drop avm_read, go to DONE (done pulses, id_match=0); timeout_err cleared only by reset or next accepted start.
REQ-031 Without SYSID_PROBE_TIMEOUT_EN, no counter SHALL exist, timeout_err SHALL be tied 0, and the controller waits indefinitely.

Verification
REQ-032 EXPECTED_ID=32'h6068_33B6, slave returns 32'h6068_33B6/32'h0000_1234, zero wait, latency 1 -> done at cycle 5, id_match=1, ts_value=32'h1234.
REQ-033 Slave ID returns 32'h0000_0001 -> done pulses, id_match=0, id_value=32'h1.
REQ-034 avm_waitrequest=1 for 3 cycles on ID read -> avm_read/avm_address held stable 4 cycles, done at cycle 8.
REQ-035 start pulsed again while busy -> ignored; exactly one done pulse.
REQ-036 reset_n=0 during WAIT_TS, readdatavalid after release -> all outputs 0, state IDLE, no done.
REQ-037 SYSID_PROBE_TIMEOUT_EN, TIMEOUT_CYCLES=8, waitrequest held high -> timeout_err=1 and done at cycle 10; without macro -> avm_read held, no done.
